// File: rtl/jbi_snoop_out_mqueue.sv
// Outbound snoop queue for the J-Bus packet-out path.
// Each channel is an occupancy counter, because snoop requests carry no payload.
// A round-robin arbiter offers one channel at a time on a valid/ready port.
// Once a grant has been offered and stalled, it stays on the same channel until accepted.
// Every channel has full and almost-full flags and a sticky overflow error bit.
module jbi_snoop_out_mqueue #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5,
  parameter int AF_LVL = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       enq,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       afull,
  output logic [NUM_CH*CNT_W-1:0] cnt,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready,
  output logic [NUM_CH-1:0]       err_ovf,
  input  logic                    err_clr
);

  // Next count for one channel. Increments saturate at DEPTH and
  // decrements saturate at zero, so a count can never wrap.
  function automatic logic [CNT_W-1:0] cnt_upd(
    input logic [CNT_W-1:0] c,
    input logic             a,
    input logic             d
  );
    logic [CNT_W-1:0] r;
    r = c;
    if (a && !d && (c != CNT_W'(DEPTH))) r = c + CNT_W'(1);
    else if (d && !a && (c != '0))       r = c - CNT_W'(1);
    return r;
  endfunction

  // Returns the channel index after ch, wrapping to 0 after the last channel.
  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] ch);
    logic [CH_W-1:0] r;
    if (ch == CH_W'(NUM_CH - 1)) r = '0;
    else                         r = ch + CH_W'(1);
    return r;
  endfunction

  logic [CNT_W-1:0]  cnt_p0 [NUM_CH];
  logic              lock_p0;
  logic [CH_W-1:0]   lock_ch_p0;
  logic [CH_W-1:0]   rr_ptr_p0;
  logic [NUM_CH-1:0] err_p0;

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] deq;
  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] ovf;
  logic [CH_W-1:0]   search_ch;
  logic              handshake;
  logic              stall;

  // ---- stage p0: status decoded from the registered counts ----
  // Flags and count outputs are decoded from the registered counts only.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      nonempty[i] = (cnt_p0[i] != '0);
      full[i]     = (cnt_p0[i] == CNT_W'(DEPTH));
      afull[i]    = (cnt_p0[i] >= CNT_W'(AF_LVL));
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_cnt_out
      assign cnt[g*CNT_W +: CNT_W] = cnt_p0[g];
    end
  endgenerate

  assign out_valid = |nonempty;
  assign err_ovf   = err_p0;

  // Round-robin search: pick the first nonempty channel at or after rr_ptr.
  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    search_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_p0) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && nonempty[idx]) begin
        found     = 1'b1;
        search_ch = CH_W'(idx);
      end
    end
  end

  // A stalled grant holds its channel. That channel cannot empty while it
  // is held, because only a dequeue removes snoops.
  assign out_ch    = lock_p0 ? lock_ch_p0 : search_ch;
  assign handshake = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;

  // Per-channel dequeue, acceptance and overflow. An enqueue to a full
  // channel still fits when that channel is dequeued in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      deq[i] = handshake & (out_ch == CH_W'(i));
      acc[i] = enq[i] & (~full[i] | deq[i]);
      ovf[i] = enq[i] & full[i] & ~deq[i];
    end
  end

  // ---- stage p0 registers: counts, grant lock, round-robin pointer, errors ----
  // Count registers. Reset discards every snoop still queued.
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_cnt_reg
      always_ff @(posedge clk) begin
        if (rst) cnt_p0[g] <= '0;
        else     cnt_p0[g] <= cnt_upd(cnt_p0[g], acc[g], deq[g]);
      end
    end
  endgenerate

  // Grant lock. A stall latches the offered channel, and the handshake releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_p0    <= 1'b0;
      lock_ch_p0 <= '0;
    end else if (stall) begin
      lock_p0    <= 1'b1;
      lock_ch_p0 <= out_ch;
    end else begin
      lock_p0    <= 1'b0;
    end
  end

  // Round-robin pointer. It moves past the channel just served on each handshake.
  always_ff @(posedge clk) begin
    if (rst)            rr_ptr_p0 <= '0;
    else if (handshake) rr_ptr_p0 <= ch_inc(out_ch);
  end

  // Sticky overflow bits. A new overflow in the same cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) err_p0 <= '0;
    else     err_p0 <= (err_p0 & ~{NUM_CH{err_clr}}) | ovf;
  end

endmodule

// File: tb/tb_jbi_snoop_out_mqueue.sv
// Directed bench for jbi_snoop_out_mqueue. It uses hand-computed expected values.
module tb_jbi_snoop_out_mqueue;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  localparam int AF_LVL = 12;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       enq = '0;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       afull;
  logic [NUM_CH*CNT_W-1:0] cnt;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic                    out_ready = 1'b0;
  logic [NUM_CH-1:0]       err_ovf;
  logic                    err_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  jbi_snoop_out_mqueue #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .AF_LVL(AF_LVL)
  ) dut (
    .clk(clk), .rst(rst), .enq(enq), .full(full), .afull(afull), .cnt(cnt),
    .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready),
    .err_ovf(err_ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic int getcnt(input int ch);
    return int'(cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enq = '0; out_ready = 1'b0; err_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Invariants sampled on the falling edge
  logic            prev_hold = 1'b0;
  logic [CH_W-1:0] prev_ch   = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold && out_ch !== prev_ch)
        $display("FAIL inv_stable out_ch=%0d held=%0d", out_ch, prev_ch);
      if (out_valid && getcnt(int'(out_ch)) == 0)
        $display("FAIL inv_valid_nonempty out_ch=%0d cnt=0", out_ch);
      for (int i = 0; i < NUM_CH; i++)
        if (getcnt(i) > DEPTH) $display("FAIL inv_depth ch=%0d cnt=%0d", i, getcnt(i));
    end
    prev_hold = out_valid & ~out_ready & ~rst;
    prev_ch   = out_ch;
  end

  task automatic test_reset();
    rst = 1'b1; enq = '0; out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++; if (cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%h want=0", cnt); end
    total++; if (full !== '0 || afull !== '0) begin bad++; $display("FAIL rst_flags full=%b afull=%b want=0", full, afull); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (out_ch !== '0) begin bad++; $display("FAIL rst_ch got=%0d want=0", out_ch); end
    total++; if (err_ovf !== '0) begin bad++; $display("FAIL rst_err got=%b want=0", err_ovf); end
  endtask

  task automatic test_enq_deq();
    do_reset();
    enq = 4'b0010;
    tick(); tick(); tick();
    enq = '0;
    total++; if (getcnt(1) !== 3) begin bad++; $display("FAIL ed_cnt got=%0d want=3", getcnt(1)); end
    total++; if (out_valid !== 1'b1 || out_ch !== 2'd1) begin bad++; $display("FAIL ed_grant valid=%b ch=%0d want 1/1", out_valid, out_ch); end
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (getcnt(1) !== 3 - k) begin bad++; $display("FAIL ed_drain k=%0d got=%0d want=%0d", k, getcnt(1), 3 - k); end
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ed_empty valid=%b want=0", out_valid); end
  endtask

  task automatic test_full_ovf();
    int e;
    do_reset();
    enq = 4'b0100;
    for (int k = 1; k <= 18; k++) begin
      tick();
      e = (k > DEPTH) ? DEPTH : k;
      total++; if (getcnt(2) !== e) begin bad++; $display("FAIL fo_cnt k=%0d got=%0d want=%0d", k, getcnt(2), e); end
      total++; if (afull[2] !== (e >= AF_LVL)) begin bad++; $display("FAIL fo_afull k=%0d got=%b want=%b", k, afull[2], e >= AF_LVL); end
      total++; if (full[2] !== (e == DEPTH)) begin bad++; $display("FAIL fo_full k=%0d got=%b want=%b", k, full[2], e == DEPTH); end
      total++; if (err_ovf !== ((k >= 17) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL fo_err k=%0d got=%b", k, err_ovf); end
    end
    enq = '0; err_clr = 1'b1;
    tick();
    total++; if (err_ovf !== 4'b0000) begin bad++; $display("FAIL fo_clr got=%b want=0000", err_ovf); end
    enq = 4'b0100;
    tick();
    total++; if (err_ovf !== 4'b0100) begin bad++; $display("FAIL fo_setwins got=%b want=0100", err_ovf); end
    enq = '0;
    tick();
    err_clr = 1'b0;
    total++; if (err_ovf !== 4'b0000 || getcnt(2) !== DEPTH) begin bad++; $display("FAIL fo_final err=%b cnt=%0d want 0000/16", err_ovf, getcnt(2)); end
  endtask

  task automatic test_full_deq();
    do_reset();
    enq = 4'b0001;
    for (int k = 0; k < DEPTH; k++) tick();
    total++; if (full[0] !== 1'b1 || out_ch !== 2'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL fd_pre full=%b ch=%0d valid=%b", full[0], out_ch, out_valid); end
    out_ready = 1'b1;
    tick();
    total++; if (getcnt(0) !== DEPTH) begin bad++; $display("FAIL fd_cnt got=%0d want=16", getcnt(0)); end
    total++; if (err_ovf !== 4'b0000) begin bad++; $display("FAIL fd_err got=%b want=0000", err_ovf); end
    enq = '0;
    tick();
    out_ready = 1'b0;
    total++; if (getcnt(0) !== DEPTH - 1 || full[0] !== 1'b0) begin bad++; $display("FAIL fd_drain cnt=%0d full=%b want 15/0", getcnt(0), full[0]); end
  endtask

  task automatic test_round_robin();
    logic [CH_W-1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    do_reset();
    enq = 4'b1011;
    tick(); tick();
    enq = '0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      total++; if (out_valid !== 1'b1 || out_ch !== seq[k]) begin bad++; $display("FAIL rr_grant k=%0d valid=%b ch=%0d want=%0d", k, out_valid, out_ch, seq[k]); end
      tick();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_empty valid=%b want=0", out_valid); end
  endtask

  task automatic test_lock();
    do_reset();
    enq = 4'b0101;
    tick();
    enq = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      total++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL lk_hold k=%0d ch=%0d valid=%b want 0/1", k, out_ch, out_valid); end
      tick();
      enq = '0;
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_ch !== 2'd1) begin bad++; $display("FAIL lk_next1 got=%0d want=1", out_ch); end
    tick();
    total++; if (out_ch !== 2'd2) begin bad++; $display("FAIL lk_next2 got=%0d want=2", out_ch); end
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lk_empty valid=%b want=0", out_valid); end
    // rr_ptr is now 3: lock channel 1, then make channel 3 nonempty as well
    enq = 4'b0010;
    tick();
    enq = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_ch !== 2'd1) begin bad++; $display("FAIL lk_hold2 k=%0d ch=%0d want=1", k, out_ch); end
      tick();
      enq = '0;
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_ch !== 2'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL lk_after ch=%0d valid=%b want 3/1", out_ch, out_valid); end
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lk_empty2 valid=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enq = 4'b0001;
    for (int k = 0; k < DEPTH + 1; k++) tick();
    enq = 4'b1111;
    tick(); tick();
    total++; if (err_ovf[0] !== 1'b1 || getcnt(3) !== 2) begin bad++; $display("FAIL rm_pre err=%b cnt3=%0d want 1/2", err_ovf, getcnt(3)); end
    rst = 1'b1; enq = 4'b1111; out_ready = 1'b1;
    tick();
    total++; if (cnt !== '0) begin bad++; $display("FAIL rm_cnt got=%h want=0", cnt); end
    total++; if (out_valid !== 1'b0 || out_ch !== '0) begin bad++; $display("FAIL rm_out valid=%b ch=%0d want 0/0", out_valid, out_ch); end
    total++; if (err_ovf !== '0 || full !== '0) begin bad++; $display("FAIL rm_err err=%b full=%b want 0/0", err_ovf, full); end
    rst = 1'b0; enq = 4'b0100; out_ready = 1'b0;
    tick();
    enq = '0;
    total++; if (out_ch !== 2'd2 || getcnt(2) !== 1) begin bad++; $display("FAIL rm_after ch=%0d cnt2=%0d want 2/1", out_ch, getcnt(2)); end
  endtask

  initial begin
    test_reset();
    test_enq_deq();
    test_full_ovf();
    test_full_deq();
    test_round_robin();
    test_lock();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
